// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: holds a challenge on the MUX selects, runs NVOTE
// precharge/evaluate cycles, samples the synchronized arbiter output and returns a majority vote.
module puf_challenge_sequencer #(
    parameter int unsigned CW     = 16,
    parameter int unsigned SETTLE = 8,
    parameter int unsigned NVOTE  = 5
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic [CW-1:0] ichal,
    input  logic          ichal_valid,
    output logic          ochal_ready,
    output logic [CW-1:0] ochal,
    output logic          olaunch,
    input  logic          iresp,
    output logic          oresp,
    output logic [3:0]    oones,
    output logic          ostable,
    output logic          oresp_valid,
    input  logic          iresp_ready
);
    localparam logic [7:0] PHASE_LAST = 8'(SETTLE - 1);
    localparam logic [3:0] VOTE_LAST  = 4'(NVOTE - 1);
    localparam logic [3:0] NV         = 4'(NVOTE);
    localparam logic [3:0] HALF       = 4'(NVOTE / 2);

    typedef enum logic [2:0] {IDLE, PRE, EVAL, SAMPLE, DONE} state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] phase;
    logic [3:0] votes;
    logic [3:0] ones;
    logic [3:0] ones_next;
    logic       sync1;
    logic       sync2;
    logic       phase_end;
    logic       last_vote;

    assign ochal_ready = (state == IDLE);
    assign phase_end   = (phase == PHASE_LAST);
    assign last_vote   = (votes == VOTE_LAST);
    assign ones_next   = ones + {3'b000, sync2};

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ichal_valid) next_state = PRE;
            PRE:     if (phase_end) next_state = EVAL;
            EVAL:    if (phase_end) next_state = SAMPLE;
            SAMPLE:  next_state = last_vote ? DONE : PRE;
            DONE:    if (iresp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            ochal       <= '0;
            olaunch     <= 1'b0;
            oresp       <= 1'b0;
            oones       <= '0;
            ostable     <= 1'b0;
            oresp_valid <= 1'b0;
            phase       <= '0;
            votes       <= '0;
            ones        <= '0;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
        end else begin
            sync1       <= iresp;
            sync2       <= sync1;
            // Launch and valid are registered from the next state so they align with the state cycles.
            olaunch     <= (next_state == EVAL) || (next_state == SAMPLE);
            oresp_valid <= (next_state == DONE);
            if ((state == PRE || state == EVAL) && !phase_end) begin
                phase <= phase + 8'd1;
            end else begin
                phase <= '0;
            end
            case (state)
                IDLE: begin
                    if (ichal_valid) begin
                        ochal <= ichal;
                        votes <= '0;
                        ones  <= '0;
                    end
                end
                SAMPLE: begin
                    ones  <= ones_next;
                    votes <= votes + 4'd1;
                    if (last_vote) begin
                        oones   <= ones_next;
                        oresp   <= (ones_next > HALF);
                        ostable <= (ones_next == 4'd0) || (ones_next == NV);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench: default instance plus a SETTLE=3/NVOTE=1 corner instance, checked against
// timing and vote results computed arithmetically from the per-vote response pattern.
module tb_puf_challenge_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] chal;
    logic        valid_d;
    logic        valid_c;
    logic        resp_in;
    logic        resp_ready;

    logic        d_ready, d_launch, d_resp, d_stable, d_valid;
    logic [15:0] d_chal;
    logic [3:0]  d_ones;
    logic        c_ready, c_launch, c_resp, c_stable, c_valid;
    logic [15:0] c_chal;
    logic [3:0]  c_ones;

    int          sel;
    logic        o_ready, o_launch, o_resp, o_stable, o_valid;
    logic [15:0] o_chal;
    logic [3:0]  o_ones;

    int n_asserts = 0;
    int n_fail    = 0;

    puf_challenge_sequencer dut (
        .iclk(clk), .irst_n(rst_n), .ichal(chal), .ichal_valid(valid_d),
        .ochal_ready(d_ready), .ochal(d_chal), .olaunch(d_launch), .iresp(resp_in),
        .oresp(d_resp), .oones(d_ones), .ostable(d_stable), .oresp_valid(d_valid),
        .iresp_ready(resp_ready)
    );

    puf_challenge_sequencer #(.CW(16), .SETTLE(3), .NVOTE(1)) dut_c (
        .iclk(clk), .irst_n(rst_n), .ichal(chal), .ichal_valid(valid_c),
        .ochal_ready(c_ready), .ochal(c_chal), .olaunch(c_launch), .iresp(resp_in),
        .oresp(c_resp), .oones(c_ones), .ostable(c_stable), .oresp_valid(c_valid),
        .iresp_ready(resp_ready)
    );

    always_comb begin
        if (sel == 0) begin
            o_ready = d_ready; o_launch = d_launch; o_resp = d_resp;
            o_stable = d_stable; o_valid = d_valid; o_chal = d_chal; o_ones = d_ones;
        end else begin
            o_ready = c_ready; o_launch = c_launch; o_resp = c_resp;
            o_stable = c_stable; o_valid = c_valid; o_chal = c_chal; o_ones = c_ones;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel == 0) valid_d = v;
        else valid_c = v;
    endtask

    // pat bit v is the arbiter response presented during vote v+1.
    task automatic run(input int s, input int n, input logic [15:0] c, input logic [14:0] pat,
                       input int hold, input bit pend_en, input logic [15:0] pend);
        int   guard;
        int   period;
        int   total;
        int   ones_exp;
        logic exp_resp;
        logic exp_stable;
        chal = c;
        set_valid(1'b1);
        guard = 0;
        while (o_ready !== 1'b1 && guard < 300) begin
            step();
            guard++;
        end
        chk("accept_ready", o_ready, 1);
        step();
        set_valid(1'b0);
        period   = 2 * s + 1;
        total    = n * period;
        ones_exp = 0;
        for (int v = 0; v < n; v++) ones_exp += int'(pat[v]);
        exp_resp   = (ones_exp > n / 2);
        exp_stable = (ones_exp == 0) || (ones_exp == n);
        for (int cyc = 1; cyc <= total; cyc++) begin
            int pos;
            int v;
            pos = (cyc - 1) % period;
            v   = (cyc - 1) / period;
            if (pos == 0) begin
                resp_in = pat[v];
                chk("chal_hold", o_chal, c);
                chk("busy_ready", o_ready, 0);
            end
            chk("launch", o_launch, pos >= s);
            chk("valid_early", o_valid, 0);
            resp_ready = 1'($urandom_range(0, 1));
            step();
        end
        resp_ready = 1'b0;
        chk("valid", o_valid, 1);
        chk("resp", o_resp, exp_resp);
        chk("ones", o_ones, ones_exp);
        chk("stable", o_stable, exp_stable);
        chk("launch_done", o_launch, 0);
        chk("done_ready", o_ready, 0);
        for (int h = 0; h < hold; h++) begin
            if (pend_en && h == 2) begin
                chal = pend;
                set_valid(1'b1);
            end
            step();
            chk("hold_valid", o_valid, 1);
            chk("hold_resp", o_resp, exp_resp);
            chk("hold_ones", o_ones, ones_exp);
            chk("hold_stable", o_stable, exp_stable);
            chk("hold_ready", o_ready, 0);
            chk("hold_chal", o_chal, c);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("release_valid", o_valid, 0);
        chk("release_ready", o_ready, 1);
        chk("release_chal", o_chal, c);
    endtask

    initial begin
        rst_n = 1'b0; chal = '0; valid_d = 1'b0; valid_c = 1'b0;
        resp_in = 1'b0; resp_ready = 1'b0; sel = 0;
        repeat (3) step();
        chk("rst_ready", d_ready, 1);
        chk("rst_launch", d_launch, 0);
        chk("rst_valid", d_valid, 0);
        chk("rst_chal", d_chal, 0);
        chk("rst_ones", d_ones, 0);
        chk("rst_c_chal", c_chal, 0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", d_ready, 1);
        chk("idle_launch", d_launch, 0);

        run(8, 5, 16'hA5C3, 15'h001F, 0, 1'b0, 16'h0);
        run(8, 5, 16'h0F1E, 15'h000D, 0, 1'b0, 16'h0);
        run(8, 5, 16'h7777, 15'h0005, 0, 1'b0, 16'h0);

        run(8, 5, 16'h1234, 15'h0016, 20, 1'b1, 16'hBEEF);
        run(8, 5, 16'hBEEF, 15'h0000, 0, 1'b0, 16'h0);

        chal = 16'h5A5A;
        valid_d = 1'b1;
        step();
        valid_d = 1'b0;
        chk("mid_chal", d_chal, 16'h5A5A);
        repeat (45) step();
        chk("mid_eval_launch", d_launch, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_ready", d_ready, 1);
        chk("mid_rst_launch", d_launch, 0);
        chk("mid_rst_chal", d_chal, 0);
        chk("mid_rst_valid", d_valid, 0);
        step();
        run(8, 5, 16'hC001, 15'h001B, 0, 1'b0, 16'h0);

        for (int i = 0; i < 4; i++) begin
            logic [15:0] rc;
            logic [14:0] rp;
            rc = 16'($urandom);
            rp = 15'($urandom);
            run(8, 5, rc, rp, int'($urandom_range(0, 3)), 1'b0, 16'h0);
        end

        sel = 1;
        run(3, 1, 16'h0F0F, 15'h0000, 0, 1'b0, 16'h0);
        run(3, 1, 16'hF00D, 15'h0001, 2, 1'b0, 16'h0);
        for (int i = 0; i < 2; i++) begin
            logic [15:0] rc;
            rc = 16'($urandom);
            run(3, 1, rc, 15'($urandom_range(0, 1)), 0, 1'b0, 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
- Control stage directly upstream of the MUX2to1 delay-chain groups in the arbiter-PUF datapath.
- Accepts a challenge word over a valid/ready handshake and holds it on the per-stage select lines (isel of each MUX group).
- Drives the launch edge into the chain's iA/iB inputs and samples the arbiter response through a synchronizer.
- Repeats the evaluation NVOTE times and returns a majority-voted response bit with a ones count and a stability flag.

Parameters:
- CW, 16: challenge width; one bit per MUX stage select.
- SETTLE, 8: cycles per precharge phase and per evaluate phase; legal range 3..255.
- NVOTE, 5: evaluations per challenge; must be odd, legal range 1..15.

Ports:
- iclk  input  1  system clock; all logic on its rising edge.
- irst_n  input  1  synchronous reset, active-low.
- ichal  input  CW  challenge word.
- ichal_valid  input  1  challenge valid.
- ochal_ready  output  1  sequencer can accept a challenge.
- ochal  output  CW  registered challenge driven to the MUX isel lines.
- olaunch  output  1  launch signal into the chain inputs (iA/iB).
- iresp  input  1  raw arbiter output, asynchronous to iclk.
- oresp  output  1  majority-voted response.
- oones  output  4  count of sampled ones across the NVOTE evaluations.
- ostable  output  1  1 when oones==0 or oones==NVOTE.
- oresp_valid  output  1  result valid.
- iresp_ready  input  1  consumer accepts the result.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (iclk, irst_n).
- Reset (irst_n=0 at a rising edge), including mid-operation:
  - state=IDLE.
  - ochal, olaunch, oresp, oones, ostable, oresp_valid all 0; vote and phase counters 0.
  - Synchronizer flops 0.
- ochal_ready is combinational: 1 exactly when state==IDLE.
- iresp passes through a 2-flop synchronizer that runs every cycle. All sampling uses the second flop.
- State machine: IDLE -> PRE -> EVAL -> SAMPLE -> (PRE or DONE) -> IDLE.
- IDLE:
  - On ichal_valid && ochal_ready: ochal<=ichal, vote counter<=0, ones counter<=0, go to PRE.
  - ochal holds its last value while in IDLE.
- PRE: olaunch=0 for exactly SETTLE cycles, then go to EVAL.
- EVAL: olaunch=1 for exactly SETTLE cycles, then go to SAMPLE.
- SAMPLE, one cycle:
  - olaunch stays 1.
  - ones counter += synchronized iresp; vote counter += 1.
  - If the new vote count == NVOTE go to DONE, else go to PRE.
- DONE:
  - oresp_valid=1; olaunch=0.
  - oresp = (ones > NVOTE/2); oones = ones; ostable as defined in Ports.
  - oresp, oones and ostable are registered and stable while oresp_valid=1.
  - On iresp_ready=1: go to IDLE; oresp_valid goes to 0 on the next cycle.
- ochal is constant from the accept edge until the DONE handshake completes.
- Timing, handshake at edge E:
  - First PRE cycle is E+1.
  - Sample k (k=1..NVOTE) occurs in cycle E + k*(2*SETTLE+1).
  - oresp_valid first asserts in cycle E + NVOTE*(2*SETTLE+1) + 1.
  - Defaults: samples at E+17, 34, 51, 68, 85; oresp_valid at E+86.
- Boundary cases:
  - ichal_valid while busy: ignored; no accept because ochal_ready=0.
  - ichal_valid asserted in the same cycle DONE completes: not accepted that cycle. It is accepted in the following IDLE cycle if still asserted.
  - iresp_ready asserted outside DONE: no effect.
  - NVOTE=1: a single evaluation; ostable is always 1.
  - Counters saturate-free: ones ≤ NVOTE ≤ 15 fits in 4 bits.
- olaunch is glitch-free (registered) and never toggles outside PRE/EVAL/SAMPLE.

Test Plan:
- Reset then idle: hold irst_n=0 for 3 cycles, release.
  -> ochal_ready=1, olaunch=0, oresp_valid=0, ochal=0.
- Basic run, defaults, iresp tied 1: send ichal=16'hA5C3, handshake at edge E.
  -> ochal=A5C3 from E+1; olaunch low E+1..E+8, high E+9..E+17.
  -> oresp_valid at E+86 with oresp=1, oones=5, ostable=1.
- Majority vote: iresp driven 1 during EVAL of votes 1, 3, 4 and 0 during votes 2, 5.
  -> oresp=1, oones=3, ostable=0.
  -> Same test with only votes 1, 3 high -> oresp=0, oones=2.
- Backpressure: hold iresp_ready=0 for 20 cycles after oresp_valid.
  -> outputs stable, ochal_ready=0, new ichal_valid ignored.
  -> Raise iresp_ready -> IDLE next cycle; pending challenge accepted one cycle later.
- Reset mid-operation: assert irst_n=0 during the third EVAL.
  -> next cycle state IDLE, olaunch=0, ochal=0, oresp_valid=0.
  -> A new challenge afterwards completes with correct timing.
- Parameter corner: SETTLE=3, NVOTE=1, iresp=0.
  -> sample at E+7, oresp_valid at E+8, oresp=0, oones=0, ostable=1.
